// File: rtl/code_loader_pkg.sv
// Shared types and helpers for the code loader.
// Checksum support is selected by the CODE_LOADER_CHECKSUM_EN macro (undefined by default).
package code_loader_pkg;

  // Loader FSM states; CHK is only reachable when checksum support is built in.
  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_LEN   = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
    ST_CHK   = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // Remaining-word counter must hold 256, so it is one bit wider than a byte.
  localparam int unsigned CNT_W = 9;

  // A length byte of zero encodes a full 256-word load.
  function automatic logic [CNT_W-1:0] word_count(input logic [7:0] n);
    return (n == 8'h00) ? CNT_W'(256) : {1'b0, n};
  endfunction

endpackage

// File: rtl/code_loader.sv
// Byte-serial code loader: shares the code memory between CPU fetches (RUN)
// and a loader that writes big-endian 16-bit words from a byte stream.
// Define CODE_LOADER_CHECKSUM_EN to add a trailing modulo-256 checksum byte.
module code_loader
  import code_loader_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_req,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [7:0]  cpu_addr,
  output logic [15:0] cpu_data,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  state_e           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      word_q, word_d;
`ifdef CODE_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
  logic             err_q, err_d;
  // After a checksum failure the CPU stays held in RUN until a new load_req.
  logic             lock_q, lock_d;
`endif

  assign mem_wdata = word_q;

`ifdef CODE_LOADER_CHECKSUM_EN
  assign load_error = err_q;
`else
  assign load_error = 1'b0;
`endif

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
`ifdef CODE_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
    err_d     = err_q;
    lock_d    = lock_q;
`endif
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    load_done = 1'b0;
    cpu_hold  = 1'b1;
    cpu_data  = '0;
    mem_addr  = addr_q;

    case (state_q)
      ST_RUN: begin
        mem_addr = cpu_addr;
        cpu_data = mem_rdata;
`ifdef CODE_LOADER_CHECKSUM_EN
        cpu_hold = lock_q;
`else
        cpu_hold = 1'b0;
`endif
        if (load_req) begin
          state_d = ST_LEN;
          addr_d  = BASE_ADDR;
`ifdef CODE_LOADER_CHECKSUM_EN
          csum_d  = '0;
          err_d   = 1'b0;
          lock_d  = 1'b0;
`endif
        end
      end

      ST_LEN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d   = word_count(in_data);
          state_d = ST_HI;
        end
      end

      ST_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d[15:8] = in_data;
`ifdef CODE_LOADER_CHECKSUM_EN
          csum_d       = csum_q + in_data;
`endif
          state_d      = ST_LO;
        end
      end

      ST_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d[7:0] = in_data;
`ifdef CODE_LOADER_CHECKSUM_EN
          csum_d      = csum_q + in_data;
`endif
          state_d     = ST_WRITE;
        end
      end

      ST_WRITE: begin
        mem_we = 1'b1;
        addr_d = addr_q + 8'd1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q != CNT_W'(1)) begin
          state_d = ST_HI;
        end else begin
`ifdef CODE_LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
`endif
        end
      end

`ifdef CODE_LOADER_CHECKSUM_EN
      ST_CHK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data == csum_q) begin
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b1;
            lock_d  = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
`endif

      ST_DONE: begin
        load_done = 1'b1;
        state_d   = ST_RUN;
      end

      default: state_d = ST_RUN;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      addr_q  <= BASE_ADDR;
      cnt_q   <= '0;
      word_q  <= '0;
`ifdef CODE_LOADER_CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
`ifdef CODE_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
      lock_q  <= lock_d;
`endif
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Directed self-checking bench for code_loader: two instances (BASE_ADDR 00 and FF)
// share all stimulus, each with its own behavioural code memory.
module tb_code_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_req = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [7:0]  cpu_addr = 8'h00;
  logic        use_force = 1'b0;
  logic [15:0] rdata_force = 16'h0000;

  logic        ready0, we0, hold0, done0, err0;
  logic [15:0] cdata0, wdata0, rdata0;
  logic [7:0]  addr0;
  logic        ready1, we1, hold1, done1, err1;
  logic [15:0] cdata1, wdata1, rdata1;
  logic [7:0]  addr1;

  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];

  int we_cnt0 = 0, we_cnt1 = 0, done_cnt0 = 0, hold_cyc0 = 0;
  int checks = 0, errors = 0;
  int we_s, we1_s, done_s, hold_s;
  logic [7:0] tb_sum;

  assign rdata0 = use_force ? rdata_force : mem0[addr0];
  assign rdata1 = mem1[addr1];

  code_loader #(.BASE_ADDR(8'h00)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .in_valid(in_valid),
    .in_data(in_data), .in_ready(ready0), .cpu_addr(cpu_addr), .cpu_data(cdata0),
    .mem_addr(addr0), .mem_wdata(wdata0), .mem_we(we0), .mem_rdata(rdata0),
    .cpu_hold(hold0), .load_done(done0), .load_error(err0)
  );

  code_loader #(.BASE_ADDR(8'hFF)) dut_ff (
    .clk(clk), .reset(reset), .load_req(load_req), .in_valid(in_valid),
    .in_data(in_data), .in_ready(ready1), .cpu_addr(cpu_addr), .cpu_data(cdata1),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_we(we1), .mem_rdata(rdata1),
    .cpu_hold(hold1), .load_done(done1), .load_error(err1)
  );

  always #5 clk = ~clk;

  // External code memories and event counters.
  always @(posedge clk) begin
    if (we0) begin
      mem0[addr0] <= wdata0;
      we_cnt0     <= we_cnt0 + 1;
    end
    if (we1) begin
      mem1[addr1] <= wdata1;
      we_cnt1     <= we_cnt1 + 1;
    end
    if (done0) done_cnt0 <= done_cnt0 + 1;
    if (hold0) hold_cyc0 <= hold_cyc0 + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and wait (bounded) until it is accepted.
  task automatic send(input logic [7:0] b, input bit gap);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!ready0 && n < 20) begin
      step();
      n++;
    end
    check("send_ready", {31'd0, ready0}, 32'd1);
    step();
    in_valid = 1'b0;
    if (gap) step();
  endtask

  task automatic send_word(input logic [15:0] w, input bit gap);
    send(w[15:8], gap);
    send(w[7:0], gap);
    tb_sum = tb_sum + w[15:8] + w[7:0];
  endtask

  task automatic start_load(input logic [7:0] n, input bit gap);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    tb_sum   = 8'h00;
    send(n, gap);
  endtask

  // Optional checksum byte, then wait (bounded) for the completion pulse.
  task automatic finish_load(input bit gap);
    int n = 0;
`ifdef CODE_LOADER_CHECKSUM_EN
    send(tb_sum, gap);
`endif
    while (!done0 && n < 10) begin
      step();
      n++;
    end
    check("finish_done", {31'd0, done0}, 32'd1);
    step();
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_hold",  {31'd0, hold0},  32'd0);
    check("rst_we",    {31'd0, we0},    32'd0);
    check("rst_ready", {31'd0, ready0}, 32'd0);
    check("rst_done",  {31'd0, done0},  32'd0);
    check("rst_wdata", {16'd0, wdata0}, 32'h0);
    check("rst_err",   {31'd0, err0},   32'd0);

    // CPU fetch path in RUN
    reset       = 1'b0;
    cpu_addr    = 8'h05;
    use_force   = 1'b1;
    rdata_force = 16'hA5C3;
    step();
    check("run_cdata", {16'd0, cdata0}, 32'hA5C3);
    check("run_hold",  {31'd0, hold0},  32'd0);
    check("run_maddr", {24'd0, addr0},  32'h05);

    // N=2, bytes 12 34 AB CD, no stalls, cycle by cycle
    we_s = we_cnt0; we1_s = we_cnt1; done_s = done_cnt0; hold_s = hold_cyc0;
    load_req = 1'b1;
    step();                                   // LEN
    load_req = 1'b0;
    check("len_ready", {31'd0, ready0}, 32'd1);
    check("len_hold",  {31'd0, hold0},  32'd1);
    check("len_cdata", {16'd0, cdata0}, 32'h0);
    check("len_addr0", {24'd0, addr0},  32'h00);
    check("len_addr1", {24'd0, addr1},  32'hFF);
    in_valid = 1'b1;
    in_data  = 8'h02;
    step();                                   // HI
    in_data = 8'h12;
    step();                                   // LO
    in_data = 8'h34;
    step();                                   // WRITE
    check("w1_we",    {31'd0, we0},    32'd1);
    check("w1_wdata", {16'd0, wdata0}, 32'h1234);
    check("w1_addr0", {24'd0, addr0},  32'h00);
    check("w1_addr1", {24'd0, addr1},  32'hFF);
    check("w1_ready", {31'd0, ready0}, 32'd0);
    in_data = 8'hAB;
    step();                                   // HI
    check("w1_we_off", {31'd0, we0}, 32'd0);
    step();                                   // LO
    in_data = 8'hCD;
    step();                                   // WRITE
    check("w2_wdata", {16'd0, wdata0}, 32'hABCD);
    check("w2_addr0", {24'd0, addr0},  32'h01);
    check("w2_addr1", {24'd0, addr1},  32'h00);
`ifdef CODE_LOADER_CHECKSUM_EN
    in_data = 8'hBE;
    step();                                   // CHK
`endif
    in_valid = 1'b0;
    step();                                   // DONE
    check("done_pulse", {31'd0, done0}, 32'd1);
    check("done_hold",  {31'd0, hold0}, 32'd1);
    step();                                   // RUN
    check("post_done",  {31'd0, done0}, 32'd0);
    check("post_hold",  {31'd0, hold0}, 32'd0);
`ifdef CODE_LOADER_CHECKSUM_EN
    check("load_cycles", hold_cyc0 - hold_s, 32'd9);
`else
    check("load_cycles", hold_cyc0 - hold_s, 32'd8);
`endif
    check("load_dones",  done_cnt0 - done_s, 32'd1);
    check("load_writes", we_cnt0 - we_s,     32'd2);
    check("m0_00", {16'd0, mem0[0]},   32'h1234);
    check("m0_01", {16'd0, mem0[1]},   32'hABCD);
    check("m1_ff", {16'd0, mem1[255]}, 32'h1234);
    check("m1_00", {16'd0, mem1[0]},   32'hABCD);
    use_force = 1'b0;
    cpu_addr  = 8'h01;
    #1;
    check("readback", {16'd0, cdata0}, 32'hABCD);

    // in_valid toggling, idle waits, and a load_req pulse mid-load
    we_s = we_cnt0; done_s = done_cnt0;
    start_load(8'h02, 1'b1);
    send_word(16'h5678, 1'b1);
    step();
    step();
    check("idle_ready", {31'd0, ready0}, 32'd1);
    check("idle_addr",  {24'd0, addr0},  32'h01);
    check("idle_we",    {31'd0, we0},    32'd0);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    check("ign_req_addr", {24'd0, addr0}, 32'h01);
    send_word(16'h9ABC, 1'b1);
    finish_load(1'b1);
    check("tog_writes", we_cnt0 - we_s,     32'd2);
    check("tog_dones",  done_cnt0 - done_s, 32'd1);
    check("tog_m0_00", {16'd0, mem0[0]},   32'h5678);
    check("tog_m0_01", {16'd0, mem0[1]},   32'h9ABC);
    check("tog_m1_ff", {16'd0, mem1[255]}, 32'h5678);
    check("tog_m1_00", {16'd0, mem1[0]},   32'h9ABC);

    // N=0 means 256 words; checks wrap for both base addresses
    we_s = we_cnt0; we1_s = we_cnt1;
    start_load(8'h00, 1'b0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send_word({b, ~b}, 1'b0);
    end
    finish_load(1'b0);
    check("n256_writes0", we_cnt0 - we_s,  32'd256);
    check("n256_writes1", we_cnt1 - we1_s, 32'd256);
    check("n256_m0_00", {16'd0, mem0[0]},   32'h00FF);
    check("n256_m0_ff", {16'd0, mem0[255]}, 32'hFF00);
    check("n256_m1_ff", {16'd0, mem1[255]}, 32'h00FF);
    check("n256_m1_00", {16'd0, mem1[0]},   32'h01FE);
    check("n256_m1_fe", {16'd0, mem1[254]}, 32'hFF00);

    // Reset while in LO aborts the load; the first word stays written
    we_s = we_cnt0; done_s = done_cnt0;
    start_load(8'h03, 1'b0);
    send_word(16'h1122, 1'b0);
    send(8'h33, 1'b0);                        // now in LO
    in_valid = 1'b1;
    in_data  = 8'h44;
    reset    = 1'b1;
    step();
    check("abort_hold",  {31'd0, hold0},  32'd0);
    check("abort_we",    {31'd0, we0},    32'd0);
    check("abort_ready", {31'd0, ready0}, 32'd0);
    check("abort_wdata", {16'd0, wdata0}, 32'h0);
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    check("abort_writes", we_cnt0 - we_s,     32'd1);
    check("abort_dones",  done_cnt0 - done_s, 32'd0);
    check("abort_m0_00", {16'd0, mem0[0]}, 32'h1122);
    check("abort_m0_01", {16'd0, mem0[1]}, 32'h01FE);

`ifdef CODE_LOADER_CHECKSUM_EN
    // Good checksum 03 for bytes 01 02
    start_load(8'h01, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    step();                                   // WRITE -> CHK
    send(8'h03, 1'b0);
    check("csum_ok_done", {31'd0, done0}, 32'd1);
    check("csum_ok_err",  {31'd0, err0},  32'd0);
    step();
    // Bad checksum 04
    done_s = done_cnt0;
    start_load(8'h01, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    step();
    send(8'h04, 1'b0);
    check("csum_bad_err",  {31'd0, err0},  32'd1);
    check("csum_bad_hold", {31'd0, hold0}, 32'd1);
    step();
    step();
    check("csum_bad_hold2", {31'd0, hold0}, 32'd1);
    check("csum_bad_nodone", done_cnt0 - done_s, 32'd0);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    check("csum_err_clear", {31'd0, err0}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("csum_rst_hold", {31'd0, hold0}, 32'd0);
`else
    check("nocsum_err", {31'd0, err0}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
